// File: rtl/downstream_update_arbiter.sv
// downstream_update_arbiter
// Round-robin arbiter that opens a memory-update window for one upstream
// channel at a time. The window closes on memwr or on timeout. memwr must
// drop before the next window is granted.
//
// state        | meaning
// -------------+------------------------------------------------------------
// IDLE         | no window open; grant the next pending channel if any
// UPDATE_MEM   | window open for grant_id; wait for memwr or timer expiry
// WAIT_RELEASE | window closed; hold off new grants until memwr is low
module downstream_update_arbiter #(
    parameter int NUM_CH  = 4,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic                      clk,
    input  logic                      HRESETn,
    input  logic [NUM_CH-1:0]         ack,
    input  logic                      memwr,
    output logic                      out,
    output logic [NUM_CH-1:0]         grant,
    output logic [$clog2(NUM_CH)-1:0] grant_id,
    output logic                      done,
    output logic                      timeout_err,
    output logic [NUM_CH-1:0]         pending,
    output logic [CNT_W-1:0]          done_count
);

    localparam int IDW  = $clog2(NUM_CH);
    localparam int IDW1 = IDW + 1;
    localparam int TW   = $clog2(TIMEOUT);

    // The window timer counts down from TIMEOUT-1; reaching zero in
    // UPDATE_MEM means the window has been open for TIMEOUT cycles.
    localparam logic [TW-1:0]   TMR_LOAD  = TW'(TIMEOUT - 1);
    localparam logic [IDW-1:0]  LAST_CH   = IDW'(NUM_CH - 1);
    localparam logic [IDW:0]    NUM_CH_W  = IDW1'(NUM_CH);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        UPDATE_MEM   = 2'd1,
        WAIT_RELEASE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [NUM_CH-1:0]   ack_q;
    logic [NUM_CH-1:0]   req_rise;
    logic [NUM_CH-1:0]   clr_mask;
    logic [NUM_CH-1:0]   grant_q;
    logic [IDW-1:0]      rr_ptr;
    logic [TW-1:0]       tmr;

    logic [NUM_CH-1:0]   rot;
    logic [IDW-1:0]      off;
    logic [IDW:0]        sum;
    logic [IDW-1:0]      pick_id;
    logic                found;

    logic                ld_grant;
    logic                finish;

    assign req_rise = ack & ~ack_q;
    assign clr_mask = finish ? grant_q : '0;
    assign grant    = out ? grant_q : '0;

    // Round-robin pick: rotate pending so rr_ptr lands at bit 0, take the
    // lowest set bit, then rotate the offset back into a channel index.
    always_comb begin
        rot   = NUM_CH'({pending, pending} >> rr_ptr);
        found = |pending;
        off   = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = IDW'(k);
            end
        end
        sum = {1'b0, rr_ptr} + {1'b0, off};
        if (sum >= NUM_CH_W) begin
            sum = sum - NUM_CH_W;
        end
        pick_id = sum[IDW-1:0];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!HRESETn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and window/status outputs; memwr beats the timer.
    always_comb begin
        state_nxt   = state;
        out         = 1'b0;
        done        = 1'b0;
        timeout_err = 1'b0;
        ld_grant    = 1'b0;
        finish      = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    ld_grant  = 1'b1;
                    state_nxt = UPDATE_MEM;
                end
            end
            UPDATE_MEM: begin
                out = 1'b1;
                if (memwr) begin
                    done      = 1'b1;
                    finish    = 1'b1;
                    state_nxt = WAIT_RELEASE;
                end else if (tmr == '0) begin
                    timeout_err = 1'b1;
                    finish      = 1'b1;
                    state_nxt   = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                if (!memwr) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request capture; a new rising edge outranks the clear for the same bit.
    always_ff @(posedge clk) begin
        if (!HRESETn) begin
            ack_q   <= '0;
            pending <= '0;
        end else begin
            ack_q   <= ack;
            pending <= (pending & ~clr_mask) | req_rise;
        end
    end

    // Grant registers, window timer and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!HRESETn) begin
            grant_q  <= '0;
            grant_id <= '0;
            tmr      <= '0;
            rr_ptr   <= '0;
        end else begin
            if (ld_grant) begin
                grant_q  <= NUM_CH'(1) << pick_id;
                grant_id <= pick_id;
                tmr      <= TMR_LOAD;
            end else if (state == UPDATE_MEM && !finish) begin
                tmr <= tmr - TW'(1);
            end
            if (finish) begin
                rr_ptr <= (grant_id == LAST_CH) ? '0 : grant_id + IDW'(1);
            end
        end
    end

    // Saturating count of windows closed by memwr.
    always_ff @(posedge clk) begin
        if (!HRESETn) begin
            done_count <= '0;
        end else if (done && done_count != '1) begin
            done_count <= done_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_downstream_update_arbiter.sv
// Directed bench for downstream_update_arbiter: a default instance for the
// arbitration/timeout scenarios and a CNT_W=2 instance for saturation.
module tb_downstream_update_arbiter;

    logic       clk;
    logic       HRESETn;
    logic [3:0] ack;
    logic       memwr;
    logic       out;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       done;
    logic       timeout_err;
    logic [3:0] pending;
    logic [7:0] done_count;

    logic       rst_s;
    logic [1:0] ack_s;
    logic       memwr_s;
    logic       out_s;
    logic [1:0] grant_s;
    logic       grant_id_s;
    logic       done_s;
    logic       timeout_err_s;
    logic [1:0] pending_s;
    logic [1:0] done_count_s;

    int compared = 0;
    int mismatched = 0;

    downstream_update_arbiter #(.NUM_CH(4), .TIMEOUT(16), .CNT_W(8)) dut (
        .clk(clk), .HRESETn(HRESETn), .ack(ack), .memwr(memwr),
        .out(out), .grant(grant), .grant_id(grant_id), .done(done),
        .timeout_err(timeout_err), .pending(pending), .done_count(done_count)
    );

    downstream_update_arbiter #(.NUM_CH(2), .TIMEOUT(4), .CNT_W(2)) dut_sat (
        .clk(clk), .HRESETn(rst_s), .ack(ack_s), .memwr(memwr_s),
        .out(out_s), .grant(grant_s), .grant_id(grant_id_s), .done(done_s),
        .timeout_err(timeout_err_s), .pending(pending_s), .done_count(done_count_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered at the first UPDATE_MEM cycle of channel id; completes it with
    // memwr in the second cycle and returns one cycle after IDLE.
    task automatic serve(input int id);
        chk("serve_out", 32'(out), 1);
        chk("serve_grant_id", 32'(grant_id), id);
        chk("serve_grant", 32'(grant), 32'(1) << id);
        cyc();
        memwr = 1'b1;
        #1;
        chk("serve_done", 32'(done), 1);
        chk("serve_tmo", 32'(timeout_err), 0);
        cyc();
        memwr = 1'b0;
        chk("serve_wr_out", 32'(out), 0);
        chk("serve_wr_grant", 32'(grant), 0);
        chk("serve_wr_done", 32'(done), 0);
        cyc();
        cyc();
    endtask

    initial begin
        HRESETn = 1'b0;
        ack     = 4'b0000;
        memwr   = 1'b0;
        rst_s   = 1'b0;
        ack_s   = 2'b00;
        memwr_s = 1'b0;

        // Reset then single request on channel 1
        cyc();
        cyc();
        chk("rst_out", 32'(out), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_tmo", 32'(timeout_err), 0);
        chk("rst_cnt", 32'(done_count), 0);
        HRESETn = 1'b1;
        ack = 4'b0010;
        cyc();
        chk("lat1_pending", 32'(pending), 4'b0010);
        chk("lat1_out", 32'(out), 0);
        cyc();
        chk("lat2_out", 32'(out), 1);
        chk("lat2_grant", 32'(grant), 4'b0010);
        chk("lat2_grant_id", 32'(grant_id), 1);
        cyc();
        chk("upd2_out", 32'(out), 1);
        chk("upd2_done", 32'(done), 0);
        cyc();
        memwr = 1'b1;
        #1;
        chk("single_done", 32'(done), 1);
        cyc();
        chk("single_wr_out", 32'(out), 0);
        chk("single_wr_done", 32'(done), 0);
        chk("single_pending", 32'(pending), 0);
        chk("single_cnt", 32'(done_count), 1);
        memwr = 1'b0;
        cyc();
        cyc();
        cyc();
        chk("hold_pending", 32'(pending), 0);
        chk("hold_out", 32'(out), 0);
        chk("idle_grant_id", 32'(grant_id), 1);

        // Round robin from rr_ptr=0 with 0,2,3 requesting together
        HRESETn = 1'b0;
        ack = 4'b0000;
        cyc();
        HRESETn = 1'b1;
        chk("rr_rst_cnt", 32'(done_count), 0);
        ack = 4'b1101;
        cyc();
        chk("rr_pending", 32'(pending), 4'b1101);
        cyc();
        serve(0);
        serve(2);
        serve(3);
        chk("rr_idle_out", 32'(out), 0);
        chk("rr_cnt", 32'(done_count), 3);

        // Channel 2 leaves rr_ptr at 3, then 0 and 3 request together
        ack = 4'b0000;
        cyc();
        ack = 4'b0100;
        cyc();
        cyc();
        serve(2);
        ack = 4'b0000;
        cyc();
        ack = 4'b1001;
        cyc();
        cyc();
        serve(3);
        serve(0);
        chk("rr2_cnt", 32'(done_count), 6);

        // Timeout on channel 2
        ack = 4'b0000;
        cyc();
        ack = 4'b0100;
        cyc();
        chk("to_pending", 32'(pending), 4'b0100);
        cyc();
        for (int i = 1; i <= 16; i++) begin
            chk("to_out", 32'(out), 1);
            chk("to_err", 32'(timeout_err), (i == 16) ? 1 : 0);
            chk("to_done", 32'(done), 0);
            cyc();
        end
        chk("to_after_out", 32'(out), 0);
        chk("to_after_err", 32'(timeout_err), 0);
        chk("to_after_pending", 32'(pending), 0);
        chk("to_after_cnt", 32'(done_count), 6);
        cyc();

        // memwr in the final window cycle, then stuck high for 5 cycles
        ack = 4'b0000;
        cyc();
        ack = 4'b0100;
        cyc();
        cyc();
        chk("col_out", 32'(out), 1);
        for (int i = 1; i < 16; i++) begin
            cyc();
        end
        chk("col_out16", 32'(out), 1);
        memwr = 1'b1;
        #1;
        chk("col_done", 32'(done), 1);
        chk("col_tmo", 32'(timeout_err), 0);
        ack = 4'b0110;
        for (int j = 1; j <= 5; j++) begin
            cyc();
            chk("stuck_out", 32'(out), 0);
            chk("stuck_grant", 32'(grant), 0);
            chk("stuck_pending", 32'(pending), 4'b0010);
        end
        memwr = 1'b0;
        chk("col_cnt", 32'(done_count), 7);
        cyc();
        chk("release_out", 32'(out), 0);
        cyc();
        serve(1);

        // Channel 1 re-requests in the cycle its own update completes
        ack = 4'b0000;
        cyc();
        ack = 4'b0010;
        cyc();
        cyc();
        chk("rereq_grant", 32'(grant), 4'b0010);
        ack = 4'b1001;
        cyc();
        chk("rereq_pending_mid", 32'(pending), 4'b1011);
        ack = 4'b1011;
        memwr = 1'b1;
        #1;
        chk("rereq_done", 32'(done), 1);
        cyc();
        chk("rereq_pending", 32'(pending), 4'b1011);
        memwr = 1'b0;
        cyc();
        cyc();
        serve(3);
        serve(0);
        serve(1);
        chk("rereq_cnt", 32'(done_count), 12);
        chk("rereq_pending_end", 32'(pending), 0);

        // Reset in the middle of an update
        ack = 4'b0000;
        cyc();
        ack = 4'b0100;
        cyc();
        cyc();
        chk("mid_out", 32'(out), 1);
        ack = 4'b1100;
        HRESETn = 1'b0;
        cyc();
        chk("mid_rst_out", 32'(out), 0);
        chk("mid_rst_grant", 32'(grant), 0);
        chk("mid_rst_pending", 32'(pending), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_tmo", 32'(timeout_err), 0);
        chk("mid_rst_cnt", 32'(done_count), 0);
        HRESETn = 1'b1;
        ack = 4'b0000;
        cyc();
        chk("mid_post_out", 32'(out), 0);
        chk("mid_post_pending", 32'(pending), 0);
        cyc();
        chk("mid_post2_out", 32'(out), 0);

        // Saturation with a 2-bit completion counter
        rst_s = 1'b1;
        cyc();
        chk("sat_rst_cnt", 32'(done_count_s), 0);
        for (int k = 1; k <= 5; k++) begin
            ack_s = 2'b01;
            cyc();
            cyc();
            chk("sat_grant", 32'(grant_s), 2'b01);
            memwr_s = 1'b1;
            #1;
            chk("sat_done", 32'(done_s), 1);
            cyc();
            chk("sat_cnt", 32'(done_count_s), (k < 3) ? k : 3);
            memwr_s = 1'b0;
            ack_s = 2'b00;
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/downstream_update_arbiter.md
Name: downstream_update_arbiter

Overview:
- Multi-channel successor to the single-channel downstream update FSM.
- Captures update requests (`ack` rising edges) from NUM_CH upstream channels and picks one with round-robin arbitration.
- Holds a memory-update window open for the granted channel until memory signals completion (`memwr`) or a timeout expires.
- Requires `memwr` to return low before the next grant; sits between the upstream cache channels and the shared downstream memory port.

Parameters:
- NUM_CH, 4, number of requesting channels (2..16).
- TIMEOUT, 16, maximum cycles spent in UPDATE_MEM before abort (must be >= 2).
- CNT_W, 8, width of the saturating completion counter.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- HRESETn  input  1  synchronous active-low reset, sampled on rising clk.
- ack  input  NUM_CH  per-channel update request, level. Only the 0->1 edge creates a request.
- memwr  input  1  memory write-complete strobe/level from the downstream memory.
- out  output  1  high while in UPDATE_MEM; update window open.
- grant  output  NUM_CH  one-hot granted channel, valid while out=1, otherwise 0.
- grant_id  output  $clog2(NUM_CH)  index of the granted channel. Holds its last value when idle.
- done  output  1  one-cycle pulse when an update completes via memwr.
- timeout_err  output  1  one-cycle pulse when an update is aborted by timeout.
- pending  output  NUM_CH  outstanding request bits.
- done_count  output  CNT_W  number of successful completions, saturating at all-ones.

Behaviour:
- Reset (HRESETn=0 at posedge): state=IDLE, pending=0, ack_q=0, rr_ptr=0, cycle counter=0.
  - Outputs at reset: out=0, grant=0, grant_id=0, done=0, timeout_err=0, done_count=0.
  - Reset has priority over every event. A reset mid-update drops the update silently: no done, no timeout_err.
- Request capture:
  - ack_q is the registered copy of ack.
  - pending[i] sets on `ack[i] & ~ack_q[i]` in any state.
  - pending[i] clears when channel i's update finishes (done or timeout).
  - If set and clear hit the same bit in the same cycle, set wins and the request stays pending.
  - Holding ack high does not re-request; ack must fall and rise again.
- States: IDLE, UPDATE_MEM, WAIT_RELEASE. The encoding is internal.
- IDLE:
  - If pending != 0, choose the first set bit searching from rr_ptr upward, wrapping at NUM_CH-1 -> 0.
  - Register grant/grant_id, clear the cycle counter, and go to UPDATE_MEM.
  - If pending == 0, stay in IDLE.
- Latency: with ack first sampled high at edge N, pending is set after edge N, and out/grant are high after edge N+1 (2 cycles).
- UPDATE_MEM (out=1):
  - If memwr=1: pulse done, clear pending[grant_id], increment done_count (saturating), rr_ptr = grant_id+1 mod NUM_CH, go to WAIT_RELEASE.
  - Else if counter == TIMEOUT-1: pulse timeout_err, clear pending[grant_id], update rr_ptr the same way, go to WAIT_RELEASE. done_count is unchanged.
  - Else the counter increments.
  - memwr takes priority over timeout in the same cycle.
  - UPDATE_MEM lasts at most TIMEOUT cycles.
- WAIT_RELEASE (out=0, grant=0): stay until memwr=0, then go to IDLE. A memwr stuck high blocks further grants indefinitely.
- When memwr is already low in UPDATE_MEM->WAIT_RELEASE, the minimum turnaround between consecutive grants is 3 cycles (UPDATE exit, WAIT_RELEASE, IDLE).
- done and timeout_err are never high in the same cycle. grant is always one-hot or zero.

Test Plan:
- Reset then single request:
  - Stimulus: HRESETn low 2 cycles; ack[1] rises; memwr pulses 1 cycle on the 3rd UPDATE cycle.
  - Response: out high 2 cycles after ack, grant=4'b0010, done pulses once, pending=0, done_count=1, return to IDLE.
- Round-robin fairness:
  - Stimulus: ack[0], ack[2], ack[3] rise in the same cycle; memwr answers each update after 1 cycle.
  - Response: grants in order 0, 2, 3; with rr_ptr=3 and new requests on 0 and 3, the grant order is 3 then 0.
- Timeout:
  - Stimulus: TIMEOUT=16, ack[2] rises, memwr held low.
  - Response: out high exactly 16 cycles, timeout_err pulses on the last, pending[2] cleared, done_count unchanged.
- memwr/timeout collision and stuck memwr:
  - Stimulus: memwr asserted exactly in cycle 16, then held high 5 cycles.
  - Response: done pulses, no timeout_err; state stays in WAIT_RELEASE 5 cycles; no new grant until memwr falls.
- Re-request during own update:
  - Stimulus: ack[1] falls and rises in the cycle memwr completes channel 1.
  - Response: pending[1] stays 1, and channel 1 is re-granted after the other pending channels per rr_ptr.
- Reset mid-update and saturation:
  - Stimulus (reset): HRESETn low during UPDATE_MEM.
  - Response (reset): next cycle out=0, pending=0, no done/timeout_err.
  - Stimulus (saturation): CNT_W=2, 5 completions.
  - Response (saturation): done_count saturates at 3.
